// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg -- shared definitions for the memory-mapped I/O block.
//   IO_BASE / IO_END : decoded address window; must match the controller.
//   IDX_*            : word register indices, (addr - IO_BASE) >> 2.
//   TCTRL_/TSTAT_/USTAT_* : bit positions inside the control/status words.
//   uart_state_e     : UART serializer FSM states.
// -----------------------------------------------------------------------------
package io_pkg;

  localparam logic [31:0] IO_BASE = 32'h0000_1000;
  localparam logic [31:0] IO_END  = 32'h0000_1027;

  localparam logic [3:0] IDX_LED    = 4'd0;
  localparam logic [3:0] IDX_SW     = 4'd1;
  localparam logic [3:0] IDX_TCTRL  = 4'd2;
  localparam logic [3:0] IDX_TLOAD  = 4'd3;
  localparam logic [3:0] IDX_TCOUNT = 4'd4;
  localparam logic [3:0] IDX_TSTAT  = 4'd5;
  localparam logic [3:0] IDX_TXDATA = 4'd6;
  localparam logic [3:0] IDX_USTAT  = 4'd7;
  localparam logic [3:0] IDX_UDIV   = 4'd8;
  localparam logic [3:0] IDX_SEG    = 4'd9;

  localparam int TCTRL_EN      = 0;
  localparam int TCTRL_AUTO    = 1;
  localparam int TCTRL_IE      = 2;
  localparam int TSTAT_EXP     = 0;
  localparam int USTAT_BUSY    = 0;
  localparam int USTAT_FULL    = 1;
  localparam int USTAT_EMPTY   = 2;
  localparam int USTAT_CNT_LSB = 3;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/io_periph_if.sv
// -----------------------------------------------------------------------------
// io_periph_if -- controller-to-peripheral access bus.
//   ioCe     : access enable
//   ioWe     : 1 = write, 0 = read (qualified by ioCe)
//   ioAddr   : byte address
//   ioWtData : write data
//   ioRdData : combinational read data from the peripheral
// master = memory/IO controller side, slave = io_periph side.
// -----------------------------------------------------------------------------
interface io_periph_if;
  logic        ioCe;
  logic        ioWe;
  logic [31:0] ioAddr;
  logic [31:0] ioWtData;
  logic [31:0] ioRdData;

  modport master (output ioCe, ioWe, ioAddr, ioWtData, input ioRdData);
  modport slave  (input ioCe, ioWe, ioAddr, ioWtData, output ioRdData);
endinterface

// File: rtl/io_uart_tx.sv
// -----------------------------------------------------------------------------
// io_uart_tx -- transmit FIFO plus 8N1 serializer.
//   clk, rst_n : clock, asynchronous active-low reset (flushes FIFO, tx idles 1)
//   push, data : enqueue a byte; dropped when full unless a pop happens too
//   div        : baud divisor, bit period = div+1 clocks, sampled at frame start
//   full, empty, count : FIFO status
//   busy       : serializer is in a frame
//   tx         : serial output, registered, idle high
// -----------------------------------------------------------------------------
module io_uart_tx
  import io_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [7:0]                    data,
  input  logic [15:0]                   div,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("io_uart_tx: FIFO_DEPTH must be a power of 2");
  end

  logic [7:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop, push_ok;

  uart_state_e      state_q, state_d;
  logic [15:0]      baud_q, baud_d, div_q, div_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bit_q, bit_d;
  logic             tx_q, tx_d;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign busy  = (state_q != UART_IDLE);
  assign tx    = tx_q;

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  always_comb begin
    pop      = (state_q == UART_IDLE) && !empty;
    push_ok  = push && (!full || pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
  end

  // NOTE: the storage array has no reset; the pointers alone decide what is valid,
  // so flushing on reset only needs the pointers and count cleared.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= data;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    div_d   = div_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    unique case (state_q)
      UART_IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          state_d = UART_START;
          shreg_d = fifo_q[rd_ptr_q];
          div_d   = div;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
        end
      end
      UART_START: begin
        if (baud_q == div_q) begin
          state_d = UART_DATA;
          baud_d  = '0;
          tx_d    = shreg_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      UART_DATA: begin
        if (baud_q == div_q) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = UART_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      UART_STOP: begin
        if (baud_q == div_q) begin
          state_d = UART_IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = UART_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= UART_IDLE;
      baud_q   <= '0;
      div_q    <= '0;
      shreg_q  <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      div_q    <= div_d;
      shreg_q  <= shreg_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/io_periph.sv
// -----------------------------------------------------------------------------
// io_periph -- memory-mapped I/O devices at 0x1000..0x1027.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : io_periph_if.slave (ioCe/ioWe/ioAddr/ioWtData in, ioRdData out)
//   sw         : asynchronous board switches (2-flop synchronized)
//   led, seg   : LED and 7-segment registers
//   uart_tx    : 8N1 serial output, idle high
//   irq        : timer interrupt level, EXP & IE
// Optional feature macro IO_PERIPH_IRQ_EN: when undefined, TCTRL.IE is not
// implemented (reads 0, ignores writes) and irq is tied low.
// -----------------------------------------------------------------------------
module io_periph
  import io_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RST    = 16'd867
) (
  input  logic        clk,
  input  logic        rst_n,
  io_periph_if.slave  bus,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [31:0] seg,
  output logic        uart_tx,
  output logic        irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

`ifdef IO_PERIPH_IRQ_EN
  localparam logic [2:0] TCTRL_MASK = 3'b111;
`else
  localparam logic [2:0] TCTRL_MASK = 3'b011;
`endif

  if (CLK_HZ == 0) begin : g_bad_clk
    $error("io_periph: CLK_HZ must be non-zero");
  end

  logic [31:0]      off;
  logic [3:0]       idx;
  logic             hit, wr, rd;
  logic [31:0]      rd_data;

  logic [15:0]      led_q, led_d, udiv_q, udiv_d;
  logic [15:0]      sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [31:0]      seg_q, seg_d, tload_q, tload_d, tcount_q, tcount_d;
  logic [2:0]       tctrl_q, tctrl_d;
  logic             exp_q, exp_d;

  logic             tx_push, tx_full, tx_empty, tx_busy;
  logic [CNT_W-1:0] tx_count;

  // Addresses below the base wrap to huge offsets and fall outside the window.
  assign off     = bus.ioAddr - IO_BASE;
  assign hit     = bus.ioCe && (off <= (IO_END - IO_BASE));
  assign idx     = off[5:2];
  assign wr      = hit && bus.ioWe;
  assign rd      = hit && !bus.ioWe;
  assign tx_push = wr && (idx == IDX_TXDATA);

  // Ordering inside this block encodes the priorities: W1C is applied before
  // the timer so a same-edge expiry keeps EXP set, and register writes come
  // last so a TLOAD write overrides the decrement.
  always_comb begin
    // NOTE: each _d starts from its hold value so no path leaves it unassigned,
    // which would otherwise infer a latch.
    led_d     = led_q;
    seg_d     = seg_q;
    udiv_d    = udiv_q;
    tctrl_d   = tctrl_q;
    tload_d   = tload_q;
    tcount_d  = tcount_q;
    exp_d     = exp_q;
    sw_meta_d = sw;
    sw_sync_d = sw_meta_q;

    if (wr && idx == IDX_TSTAT && bus.ioWtData[TSTAT_EXP]) exp_d = 1'b0;

    if (tctrl_q[TCTRL_EN]) begin
      if (tcount_q != 32'd0) begin
        tcount_d = tcount_q - 32'd1;
      end else begin
        exp_d = 1'b1;
        if (tctrl_q[TCTRL_AUTO]) tcount_d = tload_q;
        else                     tctrl_d[TCTRL_EN] = 1'b0;
      end
    end

    if (wr) begin
      case (idx)
        IDX_LED:   led_d   = bus.ioWtData[15:0];
        IDX_TCTRL: tctrl_d = bus.ioWtData[2:0] & TCTRL_MASK;
        IDX_TLOAD: begin
          tload_d  = bus.ioWtData;
          tcount_d = bus.ioWtData;
        end
        IDX_UDIV:  udiv_d  = bus.ioWtData[15:0];
        IDX_SEG:   seg_d   = bus.ioWtData;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd) begin
      case (idx)
        IDX_LED:    rd_data[15:0] = led_q;
        IDX_SW:     rd_data[15:0] = sw_sync_q;
        IDX_TCTRL:  rd_data[2:0]  = tctrl_q;
        IDX_TLOAD:  rd_data       = tload_q;
        IDX_TCOUNT: rd_data       = tcount_q;
        IDX_TSTAT:  rd_data[TSTAT_EXP] = exp_q;
        IDX_USTAT: begin
          rd_data[USTAT_BUSY]               = tx_busy;
          rd_data[USTAT_FULL]               = tx_full;
          rd_data[USTAT_EMPTY]              = tx_empty;
          rd_data[USTAT_CNT_LSB +: CNT_W]   = tx_count;
        end
        IDX_UDIV:   rd_data[15:0] = udiv_q;
        IDX_SEG:    rd_data       = seg_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q     <= '0;
      seg_q     <= '0;
      udiv_q    <= DIV_RST;
      tctrl_q   <= '0;
      tload_q   <= '0;
      tcount_q  <= '0;
      exp_q     <= 1'b0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      led_q     <= led_d;
      seg_q     <= seg_d;
      udiv_q    <= udiv_d;
      tctrl_q   <= tctrl_d;
      tload_q   <= tload_d;
      tcount_q  <= tcount_d;
      exp_q     <= exp_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end

  io_uart_tx #(.FIFO_DEPTH(FIFO_DEPTH)) u_uart_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .data  (bus.ioWtData[7:0]),
    .div   (udiv_q),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .busy  (tx_busy),
    .tx    (uart_tx)
  );

  assign bus.ioRdData = rd_data;
  assign led          = led_q;
  assign seg          = seg_q;
`ifdef IO_PERIPH_IRQ_EN
  assign irq = exp_q & tctrl_q[TCTRL_IE];
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_io_periph.sv
// -----------------------------------------------------------------------------
// tb_io_periph -- directed self-checking bench for io_periph.
// Drives the access bus on falling edges, samples outputs away from the rising
// edge, and decodes UART frames with a background receiver.
// -----------------------------------------------------------------------------
module tb_io_periph;

  localparam logic [31:0] A_LED    = 32'h1000;
  localparam logic [31:0] A_SW     = 32'h1004;
  localparam logic [31:0] A_TCTRL  = 32'h1008;
  localparam logic [31:0] A_TLOAD  = 32'h100C;
  localparam logic [31:0] A_TCOUNT = 32'h1010;
  localparam logic [31:0] A_TSTAT  = 32'h1014;
  localparam logic [31:0] A_TXDATA = 32'h1018;
  localparam logic [31:0] A_USTAT  = 32'h101C;
  localparam logic [31:0] A_UDIV   = 32'h1020;
  localparam logic [31:0] A_SEG    = 32'h1024;

`ifdef IO_PERIPH_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] sw;
  logic [15:0] led;
  logic [31:0] seg;
  logic        uart_tx;
  logic        irq;

  io_periph_if bus ();

  io_periph dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .sw      (sw),
    .led     (led),
    .seg     (seg),
    .uart_tx (uart_tx),
    .irq     (irq)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] rx_q [$];
  logic       rx_on      = 1'b0;
  logic       rx_stop_ok = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Background 8N1 receiver for a bit period of 4 clocks (UDIV = 3).
  initial begin : rx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rx_on && uart_tx === 1'b0) begin
        repeat (5) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          b[k] = uart_tx;
          if (k < 7) repeat (4) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        if (uart_tx !== 1'b1) rx_stop_ok = 1'b0;
        rx_q.push_back(b);
      end
    end
  end

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.ioCe     = 1'b1;
    bus.ioWe     = 1'b1;
    bus.ioAddr   = addr;
    bus.ioWtData = data;
    @(negedge clk);
    bus.ioCe     = 1'b0;
    bus.ioWe     = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus.ioCe   = 1'b1;
    bus.ioWe   = 1'b0;
    bus.ioAddr = addr;
    #1;
    data = bus.ioRdData;
    bus.ioCe = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    logic [31:0] exp_rd [10];
    exp_rd = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'd867, 32'h0};
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (uart_tx !== 1'b1) begin
      failures++; $display("FAIL reset_tx_in_reset: got %b expected 1", uart_tx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      bus_read(A_LED + 32'(4 * i), r);
      checks++;
      if (r !== exp_rd[i]) begin
        failures++; $display("FAIL reset_read_idx%0d: got %h expected %h", i, r, exp_rd[i]);
      end
    end
    checks++;
    if (uart_tx !== 1'b1 || irq !== 1'b0 || led !== 16'h0 || seg !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: got tx=%b irq=%b led=%h seg=%h expected 1/0/0/0",
               uart_tx, irq, led, seg);
    end
  endtask

  task automatic test_led_sw();
    logic [31:0] r;
    bus_write(A_LED, 32'h0000_A5A5);
    checks++;
    if (led !== 16'hA5A5) begin
      failures++; $display("FAIL led_out: got %h expected a5a5", led);
    end
    bus_write(A_SEG, 32'hDEAD_BEEF);
    bus_read(A_SEG, r);
    checks++;
    if (seg !== 32'hDEAD_BEEF || r !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL seg_rw: got out=%h rd=%h expected deadbeef", seg, r);
    end
    bus.ioCe = 1'b0; bus.ioWe = 1'b0; bus.ioAddr = A_SEG; #1;
    checks++;
    if (bus.ioRdData !== 32'h0) begin
      failures++; $display("FAIL read_ce_low: got %h expected 0", bus.ioRdData);
    end
    bus_read(32'h1028, r);
    checks++;
    if (r !== 32'h0) begin
      failures++; $display("FAIL read_out_of_range: got %h expected 0", r);
    end
    bus_read(32'h0FFC, r);
    checks++;
    if (r !== 32'h0) begin
      failures++; $display("FAIL read_below_base: got %h expected 0", r);
    end
    sw = 16'h1234;
    @(negedge clk);
    bus_read(A_SW, r);
    checks++;
    if (r !== 32'h0) begin
      failures++; $display("FAIL sw_latency_1clk: got %h expected 0", r);
    end
    @(negedge clk);
    bus_read(A_SW, r);
    checks++;
    if (r !== 32'h1234) begin
      failures++; $display("FAIL sw_sync: got %h expected 1234", r);
    end
  endtask

  task automatic test_timer();
    logic [31:0] r;
    logic [31:0] s;
    bus_write(A_TLOAD, 32'd3);
    bus_write(A_TCTRL, 32'h7);
    bus_read(A_TCTRL, r);
    checks++;
    if (r !== (IRQ_ON ? 32'h7 : 32'h3)) begin
      failures++; $display("FAIL tctrl_read: got %h expected %h", r, IRQ_ON ? 32'h7 : 32'h3);
    end
    for (int n = 3; n >= 0; n--) begin
      bus_read(A_TCOUNT, r);
      bus_read(A_TSTAT, s);
      checks++;
      if (r !== 32'(n) || s !== 32'h0) begin
        failures++; $display("FAIL tcount_auto_%0d: got cnt=%0d exp=%0d expected cnt=%0d exp=0", n, r, s, n);
      end
      @(negedge clk);
    end
    bus_read(A_TCOUNT, r);
    bus_read(A_TSTAT, s);
    checks++;
    if (r !== 32'd3 || s !== 32'h1 || irq !== IRQ_ON) begin
      failures++;
      $display("FAIL timer_expire_auto: got cnt=%0d exp=%0d irq=%b expected cnt=3 exp=1 irq=%b", r, s, irq, IRQ_ON);
    end
    bus_write(A_TSTAT, 32'h1);
    bus_read(A_TSTAT, s);
    bus_read(A_TCOUNT, r);
    checks++;
    if (s !== 32'h0 || irq !== 1'b0 || r !== 32'd2) begin
      failures++; $display("FAIL tstat_w1c: got exp=%0d irq=%b cnt=%0d expected 0/0/2", s, irq, r);
    end
    // One-shot mode: EN clears at expiry and TCOUNT holds 0.
    bus_write(A_TCTRL, 32'h0);
    bus_write(A_TLOAD, 32'd2);
    bus_write(A_TCTRL, 32'h5);
    for (int n = 2; n >= 0; n--) begin
      bus_read(A_TCOUNT, r);
      checks++;
      if (r !== 32'(n)) begin
        failures++; $display("FAIL tcount_oneshot_%0d: got %0d expected %0d", n, r, n);
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus_read(A_TCOUNT, r);
    bus_read(A_TSTAT, s);
    checks++;
    if (r !== 32'd0 || s !== 32'h1 || irq !== IRQ_ON) begin
      failures++; $display("FAIL oneshot_expire: got cnt=%0d exp=%0d irq=%b expected 0/1/%b", r, s, irq, IRQ_ON);
    end
    bus_read(A_TCTRL, r);
    checks++;
    if (r[0] !== 1'b0) begin
      failures++; $display("FAIL oneshot_en_clear: got en=%b expected 0", r[0]);
    end
    bus_write(A_TSTAT, 32'h1);
  endtask

  task automatic test_w1c_collision();
    logic [31:0] r;
    logic [31:0] s;
    bus_write(A_TLOAD, 32'd1);
    bus_write(A_TCTRL, 32'h3);
    @(negedge clk);
    bus_write(A_TSTAT, 32'h1);
    bus_read(A_TSTAT, s);
    bus_read(A_TCOUNT, r);
    checks++;
    if (s !== 32'h1 || r !== 32'd1) begin
      failures++; $display("FAIL w1c_vs_set: got exp=%0d cnt=%0d expected exp=1 cnt=1", s, r);
    end
    bus_write(A_TLOAD, 32'd10);
    bus_read(A_TCOUNT, r);
    checks++;
    if (r !== 32'd10) begin
      failures++; $display("FAIL load_vs_decrement: got %0d expected 10", r);
    end
    bus_write(A_TCTRL, 32'h0);
    bus_write(A_TSTAT, 32'h1);
  endtask

  task automatic test_uart_frame();
    logic [31:0] r;
    logic [41:0] tx_vec, busy_vec, tx_exp, busy_exp;
    logic [7:0]  byte_v;
    byte_v = 8'h55;
    bus_write(A_UDIV, 32'd3);
    bus_read(A_UDIV, r);
    checks++;
    if (r !== 32'd3) begin
      failures++; $display("FAIL udiv_rw: got %0d expected 3", r);
    end
    for (int i = 0; i < 42; i++) begin
      if (i >= 1 && i <= 4)       tx_exp[i] = 1'b0;
      else if (i >= 5 && i <= 36) tx_exp[i] = byte_v[(i - 5) / 4];
      else                        tx_exp[i] = 1'b1;
      busy_exp[i] = (i >= 1 && i <= 40);
    end
    bus_write(A_TXDATA, {24'h0, byte_v});
    for (int i = 0; i < 42; i++) begin
      tx_vec[i] = uart_tx;
      bus_read(A_USTAT, r);
      busy_vec[i] = r[0];
      @(negedge clk);
    end
    checks++;
    if (tx_vec !== tx_exp) begin
      failures++; $display("FAIL uart_frame_bits: got %b expected %b", tx_vec, tx_exp);
    end
    checks++;
    if (busy_vec !== busy_exp) begin
      failures++; $display("FAIL uart_busy_window: got %b expected %b", busy_vec, busy_exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [7:0]  bytes [6];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    rx_q.delete();
    rx_stop_ok = 1'b1;
    rx_on = 1'b1;
    for (int j = 0; j < 6; j++) begin
      if (j == 5) begin
        bus_read(A_USTAT, r);
        checks++;
        if (r[1] !== 1'b1) begin
          failures++; $display("FAIL fifo_full_at_6th: got full=%b expected 1", r[1]);
        end
      end
      bus_write(A_TXDATA, {24'h0, bytes[j]});
    end
    bus_read(A_USTAT, r);
    checks++;
    if (r !== 32'h23) begin
      failures++; $display("FAIL ustat_after_burst: got %h expected 23", r);
    end
    repeat (260) @(negedge clk);
    rx_on = 1'b0;
    checks++;
    if (rx_q.size() !== 5) begin
      failures++; $display("FAIL frame_count: got %0d expected 5", rx_q.size());
    end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (j >= rx_q.size() || rx_q[j] !== bytes[j]) begin
        failures++;
        $display("FAIL frame_byte_%0d: got %h expected %h", j, (j < rx_q.size()) ? rx_q[j] : 8'hxx, bytes[j]);
      end
    end
    checks++;
    if (rx_stop_ok !== 1'b1) begin
      failures++; $display("FAIL frame_stop_bits: got bad stop bit expected all 1");
    end
    bus_read(A_USTAT, r);
    checks++;
    if (r !== 32'h4) begin
      failures++; $display("FAIL ustat_drained: got %h expected 4", r);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] r;
    int          lows;
    bus_write(A_TXDATA, 32'hA5);
    bus_write(A_TXDATA, 32'h5A);
    repeat (12) @(negedge clk);
    bus_read(A_USTAT, r);
    checks++;
    if (r[0] !== 1'b1) begin
      failures++; $display("FAIL midframe_busy: got busy=%b expected 1", r[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1) begin
      failures++; $display("FAIL reset_tx_async: got %b expected 1", uart_tx);
    end
    bus_read(A_USTAT, r);
    checks++;
    if (r !== 32'h4) begin
      failures++; $display("FAIL reset_ustat: got %h expected 4", r);
    end
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    checks++;
    if (lows !== 0) begin
      failures++; $display("FAIL reset_frame_lost: got %0d low samples expected 0", lows);
    end
  endtask

  initial begin : main
    rst_n        = 1'b0;
    sw           = 16'h0;
    bus.ioCe     = 1'b0;
    bus.ioWe     = 1'b0;
    bus.ioAddr   = 32'h0;
    bus.ioWtData = 32'h0;
    test_reset();
    test_led_sw();
    test_timer();
    test_w1c_collision();
    test_uart_frame();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_periph.md
Name: io_periph

Overview:
- Memory-mapped I/O device block directly downstream of the memory/IO controller.
- Consumes ioCe/ioWe/ioAddr/ioWtData for the I/O window 0x0000_1000–0x0000_1027 and returns ioRdData.
- Holds 10 word registers: LEDs, synchronized switches, a down-counting timer, a 4-entry UART transmit FIFO with 8N1 serializer, and a 7-segment register.

Parameters:
- CLK_HZ, 100000000, system clock frequency; documentation only.
- FIFO_DEPTH, 4, UART TX FIFO entries; must be a power of 2.
- DIV_RST, 867, UART divisor reset value; bit period = DIV+1 clocks.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ioCe  in  1  access enable from the controller.
- ioWe  in  1  1 = write, 0 = read; qualified by ioCe.
- ioAddr  in  32  byte address; bits [5:2] select the register.
- ioWtData  in  32  write data.
- ioRdData  out  32  read data; combinational.
- sw  in  16  board switches; asynchronous.
- led  out  16  LED register.
- seg  out  32  7-segment display register.
- uart_tx  out  1  serial output; idle high.
- irq  out  1  timer interrupt; level.

Behaviour:
- Decoding:
  - The register index is (ioAddr − 0x1000) >> 2. Only index 0..9 responds.
  - Writes take effect at the clk edge when ioCe=1 and ioWe=1.
  - Reads are combinational when ioCe=1 and ioWe=0. ioRdData=0 when ioCe=0, the index is out of range, or the register is write-only.
  - Byte lanes are ignored; writes are full-word.
- Register map:
  - 0x1000 LED, RW [15:0].
  - 0x1004 SW, RO [15:0]. sw passes through a 2-flop synchronizer, so read latency is 2 clk.
  - 0x1008 TCTRL, RW: bit0 EN, bit1 AUTO, bit2 IE.
  - 0x100C TLOAD, RW 32b. A write also loads TCOUNT on the same edge.
  - 0x1010 TCOUNT, RO.
  - 0x1014 TSTAT: bit0 EXP; write 1 to clear.
  - 0x1018 TXDATA, WO: pushes [7:0] into the FIFO. The push is silently dropped when the FIFO is full.
  - 0x101C USTAT, RO: bit0 BUSY (serializer active), bit1 FULL, bit2 EMPTY, bits[5:3] entry count.
  - 0x1020 UDIV, RW [15:0].
  - 0x1024 SEG, RW 32b.
- Reset values: led=0, seg=0, TCTRL=0, TLOAD=0, TCOUNT=0, EXP=0, FIFO empty, UDIV=DIV_RST, uart_tx=1, irq=0, serializer in IDLE.
- Timer, evaluated each clk while EN=1:
  - If TCOUNT≠0: TCOUNT decrements.
  - If TCOUNT=0: EXP is set. TCOUNT reloads from TLOAD if AUTO=1; otherwise EN is cleared and TCOUNT holds 0.
  - EN=0 freezes TCOUNT.
  - A set event and a W1C on the same edge leave EXP=1 (set wins).
  - A TLOAD write on the same edge as a decrement: the load wins.
  - irq = EXP & IE.
- UART serializer FSM, one byte per frame:
  - IDLE: if the FIFO is non-empty, pop the head, latch it into the shift register, go to START.
  - START: uart_tx=0 for UDIV+1 clk.
  - DATA: 8 bits LSB first, each UDIV+1 clk.
  - STOP: uart_tx=1 for UDIV+1 clk, then IDLE.
  - A baud counter counts 0..UDIV and restarts on every state entry. UDIV is sampled at frame start; a mid-frame UDIV write affects the next frame only.
  - A push and pop on the same edge with the FIFO full succeeds: count is unchanged and the byte is accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: uart_tx returns to 1 immediately (asynchronous), the FIFO is flushed, and the partial frame is lost.

Optional Feature:
- Macro: IO_PERIPH_IRQ_EN.
- Defined: TCTRL.IE is implemented and irq = EXP & IE.
- Undefined: irq is tied to 0, and TCTRL bit2 reads 0 and ignores writes. EXP polling is unchanged.

Decomposition:
- Shared package io_pkg holds:
  - IO_BASE = 0x1000 and IO_END = 0x1027, which must match the controller's window.
  - The register index constants.
  - TCTRL/TSTAT/USTAT bit positions.
  - The UART FSM state enumeration.
- One sub-module, io_uart_tx: FIFO plus serializer. Interface: push, data[7:0], div[15:0], full, empty, count, busy, tx.

Test Plan:
- Reset, then read every index: 0x1020 = 867, 0x101C = 0x4, all others 0; uart_tx = 1.
- Write LED = 0x0000_A5A5 → led = 16'hA5A5 next clk. Set sw = 16'h1234 → SW reads 0x1234 from the 3rd clk on. Read 0x1028 → 0.
- TLOAD = 3, TCTRL = 0x7 → TCOUNT reads 3,2,1,0. EXP = 1 and irq = 1 on the edge after 0; TCOUNT reloads to 3. Write TSTAT = 1 → irq = 0. Repeat with AUTO = 0 → EN clears and TCOUNT stays 0.
- W1C to TSTAT on the same edge as expiry → EXP remains 1.
- UDIV = 3, TXDATA = 0x55 → uart_tx is 0 for 4 clk, then 1,0,1,0,1,0,1,0 at 4 clk each, then stop 1 for 4 clk. BUSY is 1 for exactly 40 clk.
- Write 6 bytes back-to-back with UDIV = 3 → 1 popped immediately, 4 buffered, 1 dropped (FULL = 1 at the 6th write). Exactly 5 frames appear. Assert rst_n mid-frame → uart_tx = 1 and USTAT = 0x4 immediately.
